// File: rtl/crossword_pkg.sv
// Shared constants, key codes and types for the crossword cursor/entry block.
// Board geometry and the cell-index helper live here.
package crossword_pkg;

  localparam int GRID_N = 5;
  localparam int CELLS  = GRID_N * GRID_N;

  localparam logic [7:0] KC_RIGHT = 8'h4F;
  localparam logic [7:0] KC_LEFT  = 8'h50;
  localparam logic [7:0] KC_DOWN  = 8'h51;
  localparam logic [7:0] KC_UP    = 8'h52;
  localparam logic [7:0] KC_SPACE = 8'h2C;
  localparam logic [7:0] KC_BKSP  = 8'h2A;
  localparam logic [7:0] KC_A     = 8'h04;
  localparam logic [7:0] KC_Z     = 8'h1D;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    ADVANCE
  } state_t;

  typedef enum logic [1:0] {
    DIR_R,
    DIR_L,
    DIR_D,
    DIR_U
  } dir_t;

  function automatic logic [4:0] cell_idx(
    input logic [2:0] r,
    input logic [2:0] c
  );
    return 5'(r) * 5'(GRID_N) + 5'(c);
  endfunction

endpackage

// File: rtl/cursor_entry_ctrl_if.sv
// Write port from the cursor controller into the board-letter RAM.
// Request is held stable until the RAM acknowledges.
interface cursor_entry_ctrl_if;

  logic       wr_req;
  logic [4:0] wr_addr;
  logic [4:0] wr_data;
  logic       wr_ack;

  modport master (
    output wr_req,
    output wr_addr,
    output wr_data,
    input  wr_ack
  );

  modport slave (
    input  wr_req,
    input  wr_addr,
    input  wr_data,
    output wr_ack
  );

endinterface

// File: rtl/cursor_entry_ctrl_grid_step.sv
// One-cell cursor step that skips black cells and stops at the board edge.
// Purely combinational; scans at most GRID_N-1 cells ahead.
module grid_step
  import crossword_pkg::*;
(
  input  logic [2:0]       row,
  input  logic [2:0]       col,
  input  dir_t             dir,
  input  logic [CELLS-1:0] black_mask,
  output logic [2:0]       nrow,
  output logic [2:0]       ncol,
  output logic             moved
);

  int         r;
  int         c;
  logic [4:0] idx;
  logic       found;

  always_comb begin
    nrow  = row;
    ncol  = col;
    found = 1'b0;
    r     = 0;
    c     = 0;
    idx   = '0;
    for (int k = 1; k < GRID_N; k++) begin
      r = int'(row);
      c = int'(col);
      case (dir)
        DIR_R:   c = c + k;
        DIR_L:   c = c - k;
        DIR_D:   r = r + k;
        default: r = r - k;
      endcase
      // Once off the board every later k is off too, so no wrap.
      if (!found && r >= 0 && r < GRID_N &&
          c >= 0 && c < GRID_N) begin
        idx = 5'(r * GRID_N + c);
        if (!black_mask[idx]) begin
          found = 1'b1;
          nrow  = 3'(r);
          ncol  = 3'(c);
        end
      end
    end
    moved = found;
  end

endmodule

// File: rtl/cursor_entry_ctrl.sv
// Keyboard cursor and letter-entry controller for the crossword board.
// Arrow keys move, space flips direction, letters write then auto-advance.
module cursor_entry_ctrl
  import crossword_pkg::*;
#(
  parameter int CELL_PX = 80,
  parameter int X_ORG   = 4,
  parameter int Y_ORG   = 80
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [7:0]          keycode,
  input  logic [CELLS-1:0]    black_mask,
  cursor_entry_ctrl_if.master wr,
  output logic [2:0]          cur_row,
  output logic [2:0]          cur_col,
  output logic                dir_across,
  output logic [9:0]          highlightX,
  output logic [9:0]          highlightY
);

  state_t     state_q, state_d;
  logic [7:0] key_prev;
  logic [2:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic       dir_q, dir_d;
  logic       req_q, req_d;
  logic [4:0] addr_q, addr_d;
  logic [4:0] data_q, data_d;

  logic       key_ev;
  logic       is_arrow;
  logic       is_space;
  logic       is_wr_key;
  dir_t       step_dir;
  logic [2:0] nrow;
  logic [2:0] ncol;
  logic       moved;

  assign key_ev    = (keycode != key_prev) && (keycode != 8'h00);
  assign is_arrow  = (keycode == KC_RIGHT) || (keycode == KC_LEFT) ||
                     (keycode == KC_DOWN)  || (keycode == KC_UP);
  assign is_space  = (keycode == KC_SPACE);
  assign is_wr_key = (keycode >= KC_A && keycode <= KC_Z) ||
                     (keycode == KC_BKSP);

  // Blank data marks a backspace, so ADVANCE steps backward.
  always_comb begin
    step_dir = DIR_R;
    if (state_q == ADVANCE) begin
      if (data_q == 5'd0) step_dir = dir_q ? DIR_L : DIR_U;
      else                step_dir = dir_q ? DIR_R : DIR_D;
    end else begin
      case (keycode)
        KC_LEFT: step_dir = DIR_L;
        KC_DOWN: step_dir = DIR_D;
        KC_UP:   step_dir = DIR_U;
        default: step_dir = DIR_R;
      endcase
    end
  end

  grid_step u_step (
    .row        (row_q),
    .col        (col_q),
    .dir        (step_dir),
    .black_mask (black_mask),
    .nrow       (nrow),
    .ncol       (ncol),
    .moved      (moved)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dir_d   = dir_q;
    req_d   = req_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (key_ev) begin
          unique case (1'b1)
            is_arrow: begin
              if (moved) begin
                row_d = nrow;
                col_d = ncol;
              end
            end
            is_space: dir_d = ~dir_q;
            is_wr_key: begin
              addr_d  = cell_idx(row_q, col_q);
              data_d  = (keycode == KC_BKSP) ? 5'd0
                        : 5'(keycode - 8'h03);
              req_d   = 1'b1;
              state_d = WRITE;
            end
            default: ;
          endcase
        end
      end
      WRITE: begin
        if (wr.wr_ack) begin
          req_d   = 1'b0;
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (moved) begin
          row_d = nrow;
          col_d = ncol;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      key_prev <= 8'h00;
      row_q    <= 3'd0;
      col_q    <= 3'd0;
      dir_q    <= 1'b1;
      req_q    <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 5'd0;
    end else begin
      state_q  <= state_d;
      key_prev <= keycode;
      row_q    <= row_d;
      col_q    <= col_d;
      dir_q    <= dir_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  assign wr.wr_req  = req_q;
  assign wr.wr_addr = addr_q;
  assign wr.wr_data = data_q;

  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign dir_across = dir_q;
  assign highlightX = 10'(X_ORG) + 10'(col_q) * 10'(CELL_PX);
  assign highlightY = 10'(Y_ORG) + 10'(row_q) * 10'(CELL_PX);

endmodule
